// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
//
// Scans a 16x16 red/green frame onto a row-multiplexed LED matrix. Both colour
// arrays are snapshotted once per frame, at the start of row 0's blanking
// interval. Every row is then blanked for BLANK cycles and lit for DWELL
// cycles, so the picture can never tear mid-frame.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       scan enable; low restarts the scan at row 0
//   RedPixels    red frame, [r][c] = row r, column c
//   GrnPixels    green frame, same indexing
//   RowSink      one-hot active-high row select (zero while blanking)
//   RedDriver    red column drives for the selected row
//   GrnDriver    green column drives for the selected row
//   row          index of the row currently blanking or showing
//   frame_start  one-cycle pulse after each snapshot capture
// ---------------------------------------------------------------------------
module led_matrix_scan #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0][15:0] RedPixels,
  input  logic [15:0][15:0] GrnPixels,
  output logic [15:0]       RowSink,
  output logic [15:0]       RedDriver,
  output logic [15:0]       GrnDriver,
  output logic [3:0]        row,
  output logic              frame_start
);

  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0][15:0]   r_snapRed;
  logic [15:0][15:0]   r_snapGrn;

  logic                w_capture;
  logic [15:0]         w_rowRed;
  logic [15:0]         w_rowGrn;

  // The capture point is the first blanking cycle of row 0.
  assign w_capture = (r_state == ST_BLANK) && (row == 4'd0) && (r_cnt == '0);

  // With BLANK=1 the capture edge is also the edge that lights row 0, so the
  // fresh input arrays must be used directly instead of the stale snapshot.
  assign w_rowRed = w_capture ? RedPixels[row] : r_snapRed[row];
  assign w_rowGrn = w_capture ? GrnPixels[row] : r_snapGrn[row];

  // Blank/show sequencer. Row select and both column drives are loaded on
  // the same edge so they can never disagree. enable low overrides any
  // terminal count and parks the scan at row 0 while keeping the snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_snapRed   <= '0;
      r_snapGrn   <= '0;
      RowSink     <= '0;
      RedDriver   <= '0;
      GrnDriver   <= '0;
      row         <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        r_state   <= ST_BLANK;
        r_cnt     <= '0;
        row       <= 4'd0;
        RowSink   <= '0;
        RedDriver <= '0;
        GrnDriver <= '0;
      end else begin
        case (r_state)
          ST_BLANK: begin
            if (w_capture) begin
              r_snapRed   <= RedPixels;
              r_snapGrn   <= GrnPixels;
              frame_start <= 1'b1;
            end
            if (r_cnt == BLANK_LAST) begin
              r_state   <= ST_SHOW;
              r_cnt     <= '0;
              RowSink   <= 16'd1 << row;
              RedDriver <= w_rowRed;
              GrnDriver <= w_rowGrn;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SHOW: begin
            if (r_cnt == DWELL_LAST) begin
              r_state   <= ST_BLANK;
              r_cnt     <= '0;
              row       <= row + 4'd1;
              RowSink   <= '0;
              RedDriver <= '0;
              GrnDriver <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scan
//
// Directed bench for led_matrix_scan with DWELL=4, BLANK=2 (frame = 96
// cycles). Edge E0 is the capture edge; row r is lit after E(6r+1) through
// E(6r+4) and blanked again after E(6r+5).
// ---------------------------------------------------------------------------
module tb_led_matrix_scan;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [15:0]       RowSink;
  logic [15:0]       RedDriver;
  logic [15:0]       GrnDriver;
  logic [3:0]        row;
  logic              frame_start;

  int checks;
  int failures;

  led_matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .RedPixels  (RedPixels),
    .GrnPixels  (GrnPixels),
    .RowSink    (RowSink),
    .RedDriver  (RedDriver),
    .GrnDriver  (GrnDriver),
    .row        (row),
    .frame_start(frame_start)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park the scan with one enable-low edge; the following edge is E0.
  task automatic restartScan();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    RedPixels = '0;
    GrnPixels = '0;
    RedPixels[0] = 16'hA5A5;
    repeat (3) @(negedge clk);
    checks++;
    if ({RowSink, RedDriver, GrnDriver, row, frame_start} !== 53'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h/%h/%h/%h/%b required all zero",
               RowSink, RedDriver, GrnDriver, row, frame_start);
    end
    reset = 1'b1;
    tick(); // E0
    checks++;
    if (frame_start !== 1'b1 || RowSink !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL first_capture: frame_start=%b RowSink=%h required 1/0000",
               frame_start, RowSink);
    end
    tick(); // E1
    checks++;
    if (frame_start !== 1'b0 || RowSink !== 16'h0001 || RedDriver !== 16'hA5A5) begin
      failures++;
      $display("[TB] FAIL row0_lit: fs=%b RowSink=%h Red=%h required 0/0001/a5a5",
               frame_start, RowSink, RedDriver);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++;
      if (RowSink !== 16'h0001 || RedDriver !== 16'hA5A5) begin
        failures++;
        $display("[TB] FAIL row0_hold_E%0d: RowSink=%h Red=%h required 0001/a5a5",
                 k, RowSink, RedDriver);
      end
    end
    tick(); // E5
    checks++;
    if (RowSink !== 16'h0000 || RedDriver !== 16'h0000 || row !== 4'd1) begin
      failures++;
      $display("[TB] FAIL row0_end: RowSink=%h Red=%h row=%0d required 0000/0000/1",
               RowSink, RedDriver, row);
    end
  endtask

  task automatic test_full_scan();
    for (int r = 0; r < 16; r++) begin
      RedPixels[r] = 16'h0001 << r;
      GrnPixels[r] = ~(16'h0001 << r);
    end
    restartScan();
    tick(); // E0
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL scan_capture: frame_start=%b required 1", frame_start);
    end
    for (int k = 1; k <= 95; k++) begin
      tick();
      checks++;
      if ($countones(RowSink) > 1) begin
        failures++;
        $display("[TB] FAIL scan_onehot_E%0d: RowSink=%h", k, RowSink);
      end
      if ((k % 6) == 1) begin
        checks++;
        if (RowSink !== (16'h0001 << (k / 6)) || RedDriver !== (16'h0001 << (k / 6)) ||
            GrnDriver !== ~(16'h0001 << (k / 6))) begin
          failures++;
          $display("[TB] FAIL scan_row%0d: RowSink=%h Red=%h Grn=%h required %h/%h/%h",
                   k / 6, RowSink, RedDriver, GrnDriver, 16'h0001 << (k / 6),
                   16'h0001 << (k / 6), ~(16'h0001 << (k / 6)));
        end
      end
      if (k == 91) begin
        checks++;
        if (row !== 4'd15) begin
          failures++;
          $display("[TB] FAIL scan_row15_index: row=%0d required 15", row);
        end
      end
    end
    checks++;
    if (row !== 4'd0 || RowSink !== 16'h0000 || frame_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL scan_wrap: row=%0d RowSink=%h fs=%b required 0/0000/0",
               row, RowSink, frame_start);
    end
    tick(); // E96, next capture
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL scan_next_frame: frame_start=%b required 1", frame_start);
    end
  endtask

  // Entered just after a capture edge with the full-scan pattern snapshotted.
  task automatic test_midframe();
    repeat (7) tick(); // E7: row 1 lit
    checks++;
    if (RowSink !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL mid_row1: RowSink=%h required 0002", RowSink);
    end
    RedPixels[3] = 16'hFFFF;
    repeat (12) tick(); // E19: row 3 lit
    checks++;
    if (RowSink !== 16'h0008 || RedDriver !== 16'h0008) begin
      failures++;
      $display("[TB] FAIL mid_old_frame: RowSink=%h Red=%h required 0008/0008",
               RowSink, RedDriver);
    end
    repeat (96) tick(); // row 3 of the following frame
    checks++;
    if (RowSink !== 16'h0008 || RedDriver !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL mid_new_frame: RowSink=%h Red=%h required 0008/ffff",
               RowSink, RedDriver);
    end
  endtask

  task automatic test_overlap();
    RedPixels[5][2] = 1'b1;
    GrnPixels[5][2] = 1'b1;
    restartScan();
    for (int k = 0; k <= 31; k++) begin
      tick();
      checks++;
      if ($countones(RowSink) > 1) begin
        failures++;
        $display("[TB] FAIL overlap_onehot_E%0d: RowSink=%h", k, RowSink);
      end
    end
    checks++;
    if (RowSink !== 16'h0020 || RedDriver !== 16'h0024 || GrnDriver !== 16'hFFDF) begin
      failures++;
      $display("[TB] FAIL overlap_row5: RowSink=%h Red=%h Grn=%h required 0020/0024/ffdf",
               RowSink, RedDriver, GrnDriver);
    end
  endtask

  task automatic test_enable_drop();
    restartScan();
    repeat (44) tick(); // E0..E43: row 7 lit
    checks++;
    if (RowSink !== 16'h0080 || RedDriver !== 16'h0080) begin
      failures++;
      $display("[TB] FAIL en_row7: RowSink=%h Red=%h required 0080/0080", RowSink, RedDriver);
    end
    @(negedge clk);
    enable = 1'b0;
    tick();
    checks++;
    if ({RowSink, RedDriver, GrnDriver, row, frame_start} !== 53'd0) begin
      failures++;
      $display("[TB] FAIL en_drop: got %h/%h/%h/%h/%b required all zero",
               RowSink, RedDriver, GrnDriver, row, frame_start);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0 || RowSink !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL en_parked: fs=%b RowSink=%h required 0/0000", frame_start, RowSink);
    end
    @(negedge clk);
    enable = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || RowSink !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL en_recapture: fs=%b RowSink=%h required 1/0000", frame_start, RowSink);
    end
    tick();
    checks++;
    if (RowSink !== 16'h0001 || RedDriver !== 16'h0001 || GrnDriver !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL en_row0: RowSink=%h Red=%h Grn=%h required 0001/0001/fffe",
               RowSink, RedDriver, GrnDriver);
    end
  endtask

  task automatic test_async_reset();
    restartScan();
    repeat (56) tick(); // E0..E55: row 9 lit
    checks++;
    if (RowSink !== 16'h0200 || RedDriver !== 16'h0200) begin
      failures++;
      $display("[TB] FAIL ar_row9: RowSink=%h Red=%h required 0200/0200", RowSink, RedDriver);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (RowSink !== 16'h0000 || RedDriver !== 16'h0000 || GrnDriver !== 16'h0000 ||
        row !== 4'd0) begin
      failures++;
      $display("[TB] FAIL ar_immediate: RowSink=%h Red=%h Grn=%h row=%0d required zero",
               RowSink, RedDriver, GrnDriver, row);
    end
    tick();
    checks++;
    if ({RowSink, RedDriver, GrnDriver, row, frame_start} !== 53'd0) begin
      failures++;
      $display("[TB] FAIL ar_held: got %h/%h/%h/%h/%b required all zero",
               RowSink, RedDriver, GrnDriver, row, frame_start);
    end
    RedPixels[0] = 16'h3C3C;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_capture: frame_start=%b required 1", frame_start);
    end
    tick();
    checks++;
    if (RowSink !== 16'h0001 || RedDriver !== 16'h3C3C) begin
      failures++;
      $display("[TB] FAIL ar_row0: RowSink=%h Red=%h required 0001/3c3c", RowSink, RedDriver);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_scan();
    test_midframe();
    test_overlap();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
